// File: rtl/uart_tx_8n1.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : uart_tx_8n1
// Description : 8N1 asynchronous serial transmitter. Accepts one byte over a
//               ready/start handshake and shifts out start(0), d[0]..d[7]
//               (LSB first), stop(1). The line idles high and is driven
//               straight from a flop so the pad sees no combinational path.
// Revision    : 1.0  initial release
// ============================================================================
module uart_tx_8n1 #(
    parameter int CLKS_PER_BIT = 10        // clk cycles per bit, 2..1023
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       serial_out
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] bit_cnt;
    logic [CNT_W-1:0] bit_cnt_nx;
    logic [2:0]       bit_idx;
    logic [2:0]       bit_idx_nx;
    logic [7:0]       shift_reg;
    logic [7:0]       shift_nx;
    logic             serial_nx;
    logic             done_nx;
    logic             bit_end;

    // Last clock of the current bit period; every state change happens here.
    assign bit_end  = (bit_cnt == CNT_LAST);

    // Readiness is decoded from the state so a start in the done cycle is
    // accepted immediately, giving back-to-back frames one idle-high cycle.
    assign tx_ready = (state == S_IDLE);
    assign tx_busy  = ~tx_ready;

    // State, counters, shift register and the registered line/done outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            bit_cnt    <= '0;
            bit_idx    <= 3'd0;
            shift_reg  <= 8'd0;
            serial_out <= 1'b1;
            tx_done    <= 1'b0;
        end else begin
            state      <= state_nx;
            bit_cnt    <= bit_cnt_nx;
            bit_idx    <= bit_idx_nx;
            shift_reg  <= shift_nx;
            serial_out <= serial_nx;
            tx_done    <= done_nx;
        end
    end

    // Next-state logic. The line value is computed for the state being
    // entered, so serial_out changes on the same edge as the state does.
    always_comb begin
        state_nx   = state;
        bit_cnt_nx = bit_end ? '0 : bit_cnt + 1'b1;
        bit_idx_nx = bit_idx;
        shift_nx   = shift_reg;
        serial_nx  = serial_out;
        done_nx    = 1'b0;

        case (state)
            S_IDLE: begin
                bit_cnt_nx = '0;
                serial_nx  = 1'b1;
                if (tx_start) begin
                    state_nx   = S_START;
                    shift_nx   = tx_data;
                    bit_idx_nx = 3'd0;
                    serial_nx  = 1'b0;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_nx  = S_DATA;
                    serial_nx = shift_reg[0];
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_idx == 3'd7) begin
                        state_nx  = S_STOP;
                        serial_nx = 1'b1;
                    end else begin
                        // Bit 1 of the old value becomes bit 0 after the shift.
                        bit_idx_nx = bit_idx + 3'd1;
                        shift_nx   = {1'b0, shift_reg[7:1]};
                        serial_nx  = shift_reg[1];
                    end
                end
            end
            S_STOP: begin
                serial_nx = 1'b1;
                if (bit_end) begin
                    state_nx = S_IDLE;
                    done_nx  = 1'b1;
                end
            end
            default: begin
                state_nx  = S_IDLE;
                serial_nx = 1'b1;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_8n1.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_uart_tx_8n1
// Description : Self-checking bench for uart_tx_8n1 (CLKS_PER_BIT = 10).
//               A cycle-count frame model is compared every cycle; directed
//               frames are also checked against hand-computed line patterns,
//               and a sampling receiver checks loopback bytes.
// Revision    : 1.0  initial release
// ============================================================================
module tb_uart_tx_8n1;

    localparam int C = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_start = 1'b0;
    logic       tx_ready;
    logic       tx_busy;
    logic       tx_done;
    logic       serial_out;

    int n_cmp = 0;
    int n_err = 0;
    int n_print = 0;
    int cyc = 0;
    logic chk_en = 1'b0;

    uart_tx_8n1 #(.CLKS_PER_BIT(C)) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .tx_ready   (tx_ready),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .serial_out (serial_out)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Frame model: a frame is the 10-bit pattern {stop, data, start}; while a
    // frame is active, m_n counts cycles since the accept edge (1..10C) and
    // the line shows pattern bit (m_n-1)/C. The cycle after that is idle
    // with the done pulse.
    logic       m_active = 1'b0;
    logic       m_done   = 1'b0;
    int         m_n      = 0;
    logic [9:0] m_frame  = 10'h3FF;

    always @(posedge clk) begin
        if (rst) begin
            m_active <= 1'b0;
            m_done   <= 1'b0;
            m_n      <= 0;
        end else if (!m_active) begin
            m_done <= 1'b0;
            if (tx_start) begin
                m_active <= 1'b1;
                m_n      <= 1;
                m_frame  <= {1'b1, tx_data, 1'b0};
            end
        end else if (m_n == 10 * C) begin
            m_active <= 1'b0;
            m_done   <= 1'b1;
        end else begin
            m_n <= m_n + 1;
        end
    end

    task automatic report(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            if (n_print < 40) begin
                n_print++;
                $display("FAIL %s @%0t: got %0h expected %0h", name, $time, got, exp);
            end
        end
    endtask

    // Per-cycle comparison of all outputs against the frame model.
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            report("model_serial", {31'd0, serial_out},
                   {31'd0, (m_active ? m_frame[(m_n - 1) / C] : 1'b1)});
            report("model_ready", {31'd0, tx_ready}, {31'd0, ~m_active});
            report("model_busy",  {31'd0, tx_busy},  {31'd0, m_active});
            report("model_done",  {31'd0, tx_done},  {31'd0, m_done});
        end
    end

    // Loopback receiver: hunts for a 1->0 transition, then samples mid-bit.
    logic [8:0] rx_q[$];
    initial begin
        logic       prev;
        logic [8:0] sh;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (chk_en && !rst && prev === 1'b1 && serial_out === 1'b0) begin
                repeat (C / 2 - 1) @(negedge clk);
                if (serial_out === 1'b0) begin
                    for (int b = 0; b < 9; b++) begin
                        repeat (C) @(negedge clk);
                        sh[b] = serial_out;
                    end
                    rx_q.push_back(sh);
                end
            end
            prev = serial_out;
        end
    end

    // Present a byte with tx_start for one edge; returns in cycle k+1.
    task automatic start_frame(input logic [7:0] d);
        tx_data  = d;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        tx_data  = ~d;
    endtask

    // Called in cycle k+1; returns in cycle k+101 (the done cycle).
    task automatic watch_frame(input string name, input logic [9:0] exp_line,
                               input int poke_at, input logic [7:0] poke_data,
                               output int done_cyc);
        logic [9:0] got;
        int ready_bad;
        int early_done;
        got        = 10'h000;
        ready_bad  = 0;
        early_done = 0;
        report({name, "_start_edge"}, {31'd0, serial_out}, 32'd0);
        for (int t = 1; t <= 10 * C; t++) begin
            if (poke_at > 0 && t == poke_at + 1) tx_start = 1'b0;
            if (poke_at > 0 && t == poke_at) begin
                tx_start = 1'b1;
                tx_data  = poke_data;
            end
            if (t % C == C / 2) got[t / C] = serial_out;
            if (tx_ready !== 1'b0) ready_bad++;
            if (tx_done !== 1'b0) early_done++;
            @(negedge clk);
        end
        if (poke_at > 0) tx_start = 1'b0;
        report({name, "_line"},       {22'd0, got},             {22'd0, exp_line});
        report({name, "_ready_low"},  ready_bad,                0);
        report({name, "_early_done"}, early_done,               0);
        report({name, "_done"},       {31'd0, tx_done},         32'd1);
        report({name, "_ready_end"},  {31'd0, tx_ready},        32'd1);
        report({name, "_gap_high"},   {31'd0, serial_out},      32'd1);
        done_cyc = cyc;
    endtask

    task automatic idle_check(input string name, input int n);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (serial_out !== 1'b1 || tx_done !== 1'b0 || tx_ready !== 1'b1) bad++;
        end
        report(name, bad, 0);
    endtask

    initial begin
        int d1;
        int d2;
        logic [7:0] lb_bytes[4];
        logic [9:0] lb_lines[4];

        // Reset held for two edges.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        report("rst_serial", {31'd0, serial_out}, 32'd1);
        report("rst_ready",  {31'd0, tx_ready},   32'd1);
        report("rst_busy",   {31'd0, tx_busy},    32'd0);
        report("rst_done",   {31'd0, tx_done},    32'd0);
        chk_en = 1'b1;
        rst    = 1'b0;
        idle_check("idle_50", 50);

        // Single frame 0xA5: line 0,1,0,1,0,0,1,0,1,1.
        start_frame(8'hA5);
        watch_frame("a5", 10'b1101001010, 0, 8'h00, d1);
        @(negedge clk);
        report("a5_done_one_cycle", {31'd0, tx_done}, 32'd0);
        idle_check("idle_after_a5", 10);

        // Start request while busy is ignored.
        start_frame(8'h3C);
        watch_frame("busy_3c", 10'b1001111000, 40, 8'hFF, d1);
        @(negedge clk);
        report("busy_single_done", {31'd0, tx_done}, 32'd0);
        idle_check("idle_after_3c", 10);

        // Back-to-back: second start during the done cycle.
        start_frame(8'h00);
        watch_frame("b2b_00", 10'b1000000000, 0, 8'h00, d1);
        start_frame(8'hFF);
        watch_frame("b2b_ff", 10'b1111111110, 0, 8'h00, d2);
        report("b2b_done_spacing", d2 - d1, 101);
        idle_check("idle_after_b2b", 10);

        // Reset in the middle of a 0x81 frame (cycle k+55 is d[4] = 0).
        start_frame(8'h81);
        repeat (54) @(negedge clk);
        report("midrst_before", {31'd0, serial_out}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        report("midrst_serial", {31'd0, serial_out}, 32'd1);
        report("midrst_ready",  {31'd0, tx_ready},   32'd1);
        report("midrst_done",   {31'd0, tx_done},    32'd0);
        rst = 1'b0;
        idle_check("midrst_no_done", 60);
        start_frame(8'h55);
        watch_frame("after_rst_55", 10'b1010101010, 0, 8'h00, d1);
        idle_check("idle_after_55", 20);

        // Loopback through the sampling receiver, frames back to back.
        rx_q.delete();
        lb_bytes[0] = 8'h00; lb_lines[0] = 10'b1000000000;
        lb_bytes[1] = 8'hFF; lb_lines[1] = 10'b1111111110;
        lb_bytes[2] = 8'h5A; lb_lines[2] = 10'b1010110100;
        lb_bytes[3] = 8'h81; lb_lines[3] = 10'b1100000010;
        for (int i = 0; i < 4; i++) begin
            start_frame(lb_bytes[i]);
            watch_frame($sformatf("lb%0d", i), lb_lines[i], 0, 8'h00, d1);
        end
        idle_check("idle_after_lb", 20);
        report("lb_count", rx_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < rx_q.size()) begin
                report($sformatf("lb%0d_packet_data", i), {24'd0, rx_q[i][7:0]}, {24'd0, lb_bytes[i]});
                report($sformatf("lb%0d_stop_bit", i),    {31'd0, rx_q[i][8]},   32'd1);
            end
        end

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
